// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : IF-stage controller for the 5-stage MIPS core: PC register,
//            next-PC select (sequential/jump/branch/halt), stall/flush and
//            IF/ID register. Optional perf counters under FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [31:0] C_STEP = 32'(PC_STEP);
    localparam logic [31:0] C_NOP  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc4;
    logic [31:0] w_pc4_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = r_pc + C_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= C_NOP;
            r_pc4   <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Priority chain: older (EX) branch beats younger (ID) jump, both beat stall.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (branch_taken) begin
                    w_pc_nxt    = {branch_target[31:2], 2'b00};
                    w_instr_nxt = C_NOP;
                    w_pc4_nxt   = 32'h0000_0000;
                    w_valid_nxt = 1'b0;
                end else if (jump) begin
                    w_pc_nxt    = {jump_target[31:2], 2'b00};
                    w_instr_nxt = C_NOP;
                    w_pc4_nxt   = 32'h0000_0000;
                    w_valid_nxt = 1'b0;
                end else if (stall) begin
                    w_pc_nxt    = r_pc;
                end else if (halt) begin
                    w_state_nxt = S_HALTED;
                    w_instr_nxt = C_NOP;
                    w_pc4_nxt   = 32'h0000_0000;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_instr_nxt = instr_in;
                    w_pc4_nxt   = w_pc_inc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign pc_out     = r_pc;
    assign ifid_instr = r_instr;
    assign ifid_pc4   = r_pc4;
    assign ifid_valid = r_valid;
    assign halted     = (r_state == S_HALTED);

`ifdef FETCH_PERF_EN
    logic        w_fetch_cyc;
    logic        w_stall_cyc;
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    assign w_fetch_cyc = (r_state == S_RUN) & ~branch_taken & ~jump & ~stall & ~halt;
    assign w_stall_cyc = (r_state == S_RUN) & ~branch_taken & ~jump & stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'h0000_0000;
            r_stall_count <= 32'h0000_0000;
        end else begin
            if (w_fetch_cyc) r_fetch_count <= r_fetch_count + 32'd1;
            if (w_stall_cyc) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed vector table, halted/perf sequences,
// then randomized traffic against an instruction-level reference model.
`default_nettype none

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int tests = 0;
    int fails = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt(halt),
        .instr_in(instr_in), .pc_out(pc_out), .ifid_instr(ifid_instr),
        .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .halted(halted)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : ((a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F);
    endfunction

    assign instr_in = mem(pc_out);

    // Reference model: mode 0=boot 1=run 2=halted
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
    logic        m_valid;

    task automatic model_step();
        if (reset) begin
            m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_fc = 0; m_sc = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (branch_taken || jump) begin
                m_pc = (branch_taken ? branch_target : jump_target) & ~32'h3;
                m_instr = 32'h0; m_valid = 1'b0;
            end else if (stall) begin
                m_sc = m_sc + 1;
            end else if (halt) begin
                m_mode = 2; m_instr = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = mem(m_pc); m_pc = m_pc + 4; m_pc4 = m_pc;
                m_valid = 1'b1; m_fc = m_fc + 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic h);
        reset = r; stall = s; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt; halt = h;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        r, s, b, j, h;
        logic [31:0] bt, jt;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic        e_valid, e_halt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, s, b, input logic [31:0] bt, input logic j,
                                input logic [31:0] jt, input logic h, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [31:0] e_pc4,
                                input logic e_valid, input logic e_halt);
        vec_t v;
        v.r = r; v.s = s; v.b = b; v.bt = bt; v.j = j; v.jt = jt; v.h = h;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4;
        v.e_valid = e_valid; v.e_halt = e_halt;
        return v;
    endfunction

    initial begin
        logic [2:0] k;
        // reset, boot, free run
        vt.push_back(mk(1,0,0,0,0,0,0, 32'h00, 32'h0,       32'h00, 0, 0));
        vt.push_back(mk(0,0,1,32'h300,1,32'h400,1, 32'h00, 32'h0, 32'h00, 0, 0));
        vt.push_back(mk(0,0,0,0,0,0,0, 32'h04, 32'h2008_0005, 32'h04, 1, 0));
        vt.push_back(mk(0,0,0,0,0,0,0, 32'h08, mem(32'h04), 32'h08, 1, 0));
        // stall 2 cycles at pc 8
        vt.push_back(mk(0,1,0,0,0,0,0, 32'h08, mem(32'h04), 32'h08, 1, 0));
        vt.push_back(mk(0,1,0,0,0,0,0, 32'h08, mem(32'h04), 32'h08, 1, 0));
        vt.push_back(mk(0,0,0,0,0,0,0, 32'h0C, mem(32'h08), 32'h0C, 1, 0));
        // branch beats stall and jump
        vt.push_back(mk(0,1,1,32'h40,1,32'h80,0, 32'h40, 32'h0, 32'h0, 0, 0));
        vt.push_back(mk(0,0,0,0,0,0,0, 32'h44, mem(32'h40), 32'h44, 1, 0));
        // branch in same cycle as halt prevents halt
        vt.push_back(mk(0,0,1,32'h60,0,0,1, 32'h60, 32'h0, 32'h0, 0, 0));
        vt.push_back(mk(0,0,0,0,0,0,0, 32'h64, mem(32'h60), 32'h64, 1, 0));
        // jump to 0x20 then halt
        vt.push_back(mk(0,0,0,0,1,32'h20,0, 32'h20, 32'h0, 32'h0, 0, 0));
        vt.push_back(mk(0,0,0,0,0,0,1, 32'h20, 32'h0, 32'h0, 0, 1));
        for (int i = 0; i < 10; i++) begin
            k = 3'(i);
            vt.push_back(mk(0,k[0],k[1],32'h200,k[2],32'h300,1, 32'h20, 32'h0, 32'h0, 0, 1));
        end
        // reset out of halted, boot ignores jump
        vt.push_back(mk(1,0,0,0,0,0,1, 32'h00, 32'h0, 32'h0, 0, 0));
        vt.push_back(mk(0,0,0,0,1,32'h500,0, 32'h00, 32'h0, 32'h0, 0, 0));
        // wrap and target alignment
        vt.push_back(mk(0,0,0,0,1,32'hFFFF_FFFF,0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0));
        vt.push_back(mk(0,0,0,0,0,0,0, 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1, 0));
        vt.push_back(mk(0,0,0,0,1,32'h0000_0103,0, 32'h100, 32'h0, 32'h0, 0, 0));
        vt.push_back(mk(0,0,0,0,0,0,0, 32'h104, mem(32'h100), 32'h104, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].r, vt[i].s, vt[i].b, vt[i].bt, vt[i].j, vt[i].jt, vt[i].h);
            chk($sformatf("vec%0d pc_out", i), pc_out, vt[i].e_pc);
            chk($sformatf("vec%0d ifid_instr", i), ifid_instr, vt[i].e_instr);
            chk($sformatf("vec%0d ifid_valid", i), 32'(ifid_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vt[i].e_halt));
            if (vt[i].e_valid)
                chk($sformatf("vec%0d ifid_pc4", i), ifid_pc4, vt[i].e_pc4);
        end

`ifdef FETCH_PERF_EN
        cyc(1,0,0,0,0,0,0);
        chk("perf fetch_count reset", fetch_count, 32'd0);
        chk("perf stall_count reset", stall_count, 32'd0);
        cyc(0,1,0,0,0,0,0);
        for (int i = 0; i < 5; i++) cyc(0,0,0,0,0,0,0);
        for (int i = 0; i < 3; i++) cyc(0,1,0,0,0,0,0);
        chk("perf fetch_count", fetch_count, 32'd5);
        chk("perf stall_count", stall_count, 32'd3);
        cyc(0,0,0,0,0,0,1);
        for (int i = 0; i < 3; i++) cyc(0,1,0,0,0,0,0);
        chk("perf fetch_count halted", fetch_count, 32'd5);
        chk("perf stall_count halted", stall_count, 32'd3);
`endif

        // randomized traffic against the model
        cyc(1,0,0,0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 25), ($urandom_range(99) < 10),
                $urandom(), ($urandom_range(99) < 10), $urandom(), ($urandom_range(99) < 3));
            chk("rand pc_out", pc_out, m_pc);
            chk("rand ifid_instr", ifid_instr, m_instr);
            chk("rand ifid_valid", 32'(ifid_valid), 32'(m_valid));
            chk("rand halted", 32'(halted), 32'(m_mode == 2));
            if (m_valid) chk("rand ifid_pc4", ifid_pc4, m_pc4);
`ifdef FETCH_PERF_EN
            chk("rand fetch_count", fetch_count, m_fc);
            chk("rand stall_count", stall_count, m_sc);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
